// File: rtl/io_input_controller_if.sv
// Bundles the control-unit, board I/O and write-back signals of the
// IN-instruction handshake. The controller attaches through the slave
// modport; whatever drives it (control unit plus board, or a bench) uses master.
interface io_input_controller_if #(
    parameter int SW_WIDTH = 16
);
    logic [1:0]          In;
    logic                EnableClock;
    logic                Button;
    logic [SW_WIDTH-1:0] Switches;
    logic                KeyValid;
    logic [7:0]          KeyCode;
    logic [31:0]         InData;
    logic                CpuClockEnable;
    logic                InDone;
    logic                Busy;
    logic                KeyOverrun;

    modport master (
        output In, EnableClock, Button, Switches, KeyValid, KeyCode,
        input  InData, CpuClockEnable, InDone, Busy, KeyOverrun
    );

    modport slave (
        input  In, EnableClock, Button, Switches, KeyValid, KeyCode,
        output InData, CpuClockEnable, InDone, Busy, KeyOverrun
    );
endinterface

// File: rtl/io_input_controller.sv
// Stall-and-release handshake for IN (switches) and keyboard-input
// instructions: holds the processor clock enable low, waits for a debounced
// button press/release or a key code, latches the value onto InData, then
// releases the processor for exactly one cycle.
module io_input_controller #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SW_WIDTH        = 16
) (
    input logic                  clock,
    input logic                  reset,
    io_input_controller_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        WAIT_PRESS,
        WAIT_RELEASE,
        WAIT_KEY,
        RELEASE
    } state_e;

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [1:0] IN_SW    = 2'b01;
    localparam logic [1:0] IN_KEY   = 2'b10;

    state_e              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [31:0]         in_data_q, in_data_d;
    logic                key_pend_q, key_pend_d;
    logic [7:0]          key_reg_q, key_reg_d;
    logic                overrun_q, overrun_d;
    logic                btn_meta_q, btn_s_q;
    logic [SW_WIDTH-1:0] sw_w;
    logic                stall_req;
    logic                key_consume;

    assign sw_w      = bus.Switches;
    assign stall_req = !bus.EnableClock && (bus.In == IN_SW || bus.In == IN_KEY);

    // A WAIT_KEY cycle that hands a code to InData, either from the buffer or
    // straight from the receiver strobe.
    assign key_consume = (state_q == WAIT_KEY) && (key_pend_q || bus.KeyValid);

    // Two-flop synchronizer for the asynchronous active-low button; resets released.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            btn_meta_q <= 1'b1;
            btn_s_q    <= 1'b1;
        end else begin
            // NOTE: non-blocking here so btn_s_q takes the old btn_meta_q; blocking would collapse the two stages into one.
            btn_meta_q <= bus.Button;
            btn_s_q    <= btn_meta_q;
        end
    end

    // Next-state, debounce counter and InData capture.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves it unassigned and infers a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        in_data_d = in_data_q;
        case (state_q)
            IDLE: begin
                if (!bus.EnableClock && bus.In == IN_SW) begin
                    state_d = WAIT_PRESS;
                end else if (!bus.EnableClock && bus.In == IN_KEY) begin
                    state_d = WAIT_KEY;
                end
            end
            WAIT_PRESS: begin
                if (btn_s_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    in_data_d = 32'(sw_w);
                    state_d   = WAIT_RELEASE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            WAIT_RELEASE: begin
                if (!btn_s_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RELEASE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            WAIT_KEY: begin
                if (key_pend_q) begin
                    in_data_d = {24'b0, key_reg_q};
                    state_d   = RELEASE;
                end else if (bus.KeyValid) begin
                    in_data_d = {24'b0, bus.KeyCode};
                    state_d   = RELEASE;
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Every debounce window starts from zero in the new state.
        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    // One-entry key buffer with sticky overrun flag.
    always_comb begin
        key_pend_d = key_pend_q;
        key_reg_d  = key_reg_q;
        overrun_d  = overrun_q;
        if (key_consume) begin
            // A strobe landing in the consuming cycle refills the buffer after
            // the old code leaves, so nothing is lost and no overrun is flagged.
            key_pend_d = key_pend_q && bus.KeyValid;
            if (key_pend_q && bus.KeyValid) begin
                key_reg_d = bus.KeyCode;
            end
        end else if (bus.KeyValid) begin
            key_reg_d  = bus.KeyCode;
            key_pend_d = 1'b1;
            if (key_pend_q) begin
                overrun_d = 1'b1;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            in_data_q  <= '0;
            key_pend_q <= 1'b0;
            key_reg_q  <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            in_data_q  <= in_data_d;
            key_pend_q <= key_pend_d;
            key_reg_q  <= key_reg_d;
            overrun_q  <= overrun_d;
        end
    end

    // Processor clock enable: the stall bites in the same cycle EnableClock falls.
    always_comb begin
        bus.CpuClockEnable = 1'b0;
        case (state_q)
            IDLE:    bus.CpuClockEnable = !stall_req;
            RELEASE: bus.CpuClockEnable = 1'b1;
            default: bus.CpuClockEnable = 1'b0;
        endcase
    end

    assign bus.InDone     = (state_q == RELEASE);
    assign bus.Busy       = (state_q != IDLE);
    assign bus.InData     = in_data_q;
    assign bus.KeyOverrun = overrun_q;
endmodule

// File: doc/io_input_controller.md
# io_input_controller

Completes the stall-and-release handshake that the control unit opens on an IN (`In`=01, switches) or keyboard-input (`In`=10) instruction. The control unit drops `EnableClock`; this block gates the processor clock enable, waits for a debounced button press-and-release (switches) or a keyboard code, latches the value onto `InData`, then releases the processor for exactly one cycle so the instruction retires. It sits between the board I/O (button, switches, keyboard receiver) and the datapath's clock-enable and register write-back mux.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 16: consecutive stable synchronized cycles needed to accept a button press or release (≥2).
- `SW_WIDTH`, 16: switch bus width (≤32).

Ports:
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `In`  in  2  input-source select from the control unit: 00 none, 01 switches, 10 keyboard, 11 reserved (treated as none).
- `EnableClock`  in  1  control-unit stall request; 0 requests a stall.
- `Button`  in  1  raw board button, asynchronous, active-low (0 = pressed).
- `Switches`  in  SW_WIDTH  board switches, quasi-static.
- `KeyValid`  in  1  single-cycle strobe, synchronous to `clock`, from the keyboard receiver.
- `KeyCode`  in  8  key code, valid when `KeyValid`=1.
- `InData`  out  32  latched input value to the write-back mux.
- `CpuClockEnable`  out  1  processor clock enable.
- `InDone`  out  1  one-cycle pulse at release.
- `Busy`  out  1  1 whenever state ≠ IDLE.
- `KeyOverrun`  out  1  sticky: a key code was lost.

## Operation
- `Button` passes through a 2-flop synchronizer (reset value 1 = released); only `btn_s` is used downstream.
- Key buffer: one entry (`key_pend`, `key_reg[7:0]`). `KeyValid` in any state except a consuming WAIT_KEY cycle loads `key_reg` and sets `key_pend`. If `key_pend` is already 1, the new code overwrites and `KeyOverrun` sets.
- FSM states: IDLE, WAIT_PRESS, WAIT_RELEASE, WAIT_KEY, RELEASE.
- IDLE: if `EnableClock`=0 and `In`=01, go to WAIT_PRESS. If `EnableClock`=0 and `In`=10, go to WAIT_KEY. Otherwise stay.
- WAIT_PRESS: 8-bit debounce counter increments each cycle `btn_s`=0 and clears on any cycle `btn_s`=1. When the counter reaches DEBOUNCE_CYCLES-1 with `btn_s`=0, load `InData` = zero-extended `Switches` (sampled that cycle) and go to WAIT_RELEASE.
- WAIT_RELEASE: same counter rule with `btn_s`=1. On reaching DEBOUNCE_CYCLES-1, go to RELEASE.
- WAIT_KEY: if `key_pend`=1, load `InData` = {24'b0, `key_reg`}, clear `key_pend`, and go to RELEASE. A `KeyValid` arriving in the same cycle is written to the buffer after consumption and does not set overrun. If `key_pend`=0 and `KeyValid`=1, load directly from `KeyCode` and go to RELEASE.
- RELEASE: assert `InDone`, then go to IDLE unconditionally.
- `CpuClockEnable` is combinational:
  - IDLE: 0 iff `EnableClock`=0 and `In`∈{01,10}, else 1.
  - RELEASE: 1.
  - All other states: 0.
- The debounce counter clears on every state transition.
- `InData` holds its value between captures.
- Reset: state IDLE, counter 0, `InData`=0, `key_pend`=0, `KeyOverrun`=0, `InDone`=0, `Busy`=0, synchronizer = 1. `CpuClockEnable` then follows the IDLE rule.

## Timing
- The stall takes effect in the same cycle `EnableClock` falls (combinational, in IDLE). There is no bubble before the FSM takes over.
- Switch path: after the synchronized press is stable, it takes DEBOUNCE_CYCLES cycles in WAIT_PRESS, then DEBOUNCE_CYCLES stable-release cycles in WAIT_RELEASE, then 1 RELEASE cycle. Synchronizer latency is 2 cycles on each edge.
- Key path: with a key pending, WAIT_KEY to RELEASE takes 1 cycle. Total stall from IDLE detect is 3 cycles (IDLE stalled, WAIT_KEY, RELEASE enabled).
- RELEASE lasts exactly one cycle. The processor advances on that edge, so the IDLE cycle after it sees the next opcode. Back-to-back IN instructions therefore start a fresh handshake.
- A button held across a switches IN completes only after release. A press already held when WAIT_PRESS is entered is accepted after DEBOUNCE_CYCLES cycles.
- Asynchronous reset mid-handshake returns the block to IDLE immediately and clears `InData`.

## Test plan
- Reset with `In`=00, `EnableClock`=1 -> `CpuClockEnable`=1, `Busy`=0, `InData`=0, `KeyOverrun`=0.
- DEBOUNCE_CYCLES=4, `Switches`=16'hA5A5, `In`=01, `EnableClock`=0; button low 10 cycles then high -> `CpuClockEnable`=0 throughout, `InData`=32'h0000A5A5 once the press is accepted, a single `InDone` pulse together with `CpuClockEnable`=1 for one cycle after 4 stable released cycles.
- Bounce: button low 2 cycles, high 1, low 6 (DEBOUNCE_CYCLES=4) -> counter restarts and the press is accepted only after 4 consecutive low cycles. No early release.
- `KeyValid` with `KeyCode`=8'h1C while IDLE, then `In`=10, `EnableClock`=0 -> RELEASE on the 2nd cycle, `InData`=32'h0000001C, `key_pend` cleared.
- Two `KeyValid` strobes (8'h11, then 8'h22) in IDLE -> `KeyOverrun`=1; a later key IN returns 32'h00000022.
- Assert `reset` low during WAIT_RELEASE -> `Busy`=0 and `InData`=0 immediately, without waiting for a clock edge.
